// File: rtl/tinyvga_decoder.sv
// tinyvga_decoder: TinyVGA PMOD bus to parallel RGB with recovered
// pixel coordinates, active-video flag and frame-lock detection.
module tinyvga_decoder #(
    parameter int OUT_BPC         = 8,
    parameter int EXPAND_MODE     = 1,
    parameter int SYNC_ACTIVE_LOW = 1,
    parameter int H_BP            = 48,
    parameter int H_ACTIVE        = 640,
    parameter int V_BP            = 33,
    parameter int V_ACTIVE        = 480
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         pmod_in,
    output logic [OUT_BPC-1:0] r,
    output logic [OUT_BPC-1:0] g,
    output logic [OUT_BPC-1:0] b,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [9:0]         xpos,
    output logic [9:0]         ypos,
    output logic               frame_start,
    output logic               locked
);
    localparam logic        AS     = (SYNC_ACTIVE_LOW == 0);
    localparam logic [7:0]  S1_RST = {~AS, 3'b000, ~AS, 3'b000};
    localparam logic [10:0] H_LO   = 11'(H_BP);
    localparam logic [10:0] H_HI   = 11'(H_BP + H_ACTIVE);
    localparam logic [10:0] V_LO   = 11'(V_BP);
    localparam logic [10:0] V_HI   = 11'(V_BP + V_ACTIVE);
    localparam logic [9:0]  SAT    = '1;

    // 2-bit code spread MSB-first; mode 0 keeps only the top two bits
    function automatic logic [OUT_BPC-1:0] expand(input logic [1:0] c);
        logic [OUT_BPC-1:0] e;
        for (int i = 0; i < OUT_BPC; i++)
            e[OUT_BPC-1-i] = (EXPAND_MODE == 0 && i > 1) ? 1'b0 : c[~i[0]];
        return e;
    endfunction

    logic [7:0] s1;
    logic [9:0] hcnt, vcnt, lt_cur, lt_prev;
    logic       h_trail, v_trail, h_act, v_act, de_n;

    assign h_trail = (s1[7] == AS) && (pmod_in[7] != AS);
    assign v_trail = (s1[3] == AS) && (pmod_in[3] != AS);
    assign h_act   = ({1'b0, hcnt} >= H_LO) && ({1'b0, hcnt} < H_HI);
    assign v_act   = ({1'b0, vcnt} >= V_LO) && ({1'b0, vcnt} < V_HI);
    assign de_n    = h_act && v_act;

    // counters move with the stage-1 sample, so hcnt==0 is the first pixel after hsync
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1      <= S1_RST;
            hcnt    <= '0;
            vcnt    <= '0;
            lt_cur  <= '0;
            lt_prev <= '0;
        end else begin
            s1   <= pmod_in;
            hcnt <= h_trail ? 10'd0 : (hcnt == SAT ? hcnt : hcnt + 10'd1);
            vcnt <= v_trail ? 10'd0 : (h_trail && vcnt != SAT ? vcnt + 10'd1 : vcnt);
            if (v_trail) begin
                lt_prev <= lt_cur;
                lt_cur  <= vcnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r           <= '0;
            g           <= '0;
            b           <= '0;
            hsync       <= ~AS;
            vsync       <= ~AS;
            de          <= 1'b0;
            xpos        <= '0;
            ypos        <= '0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
        end else begin
            r           <= de_n ? expand({s1[0], s1[4]}) : '0;
            g           <= de_n ? expand({s1[1], s1[5]}) : '0;
            b           <= de_n ? expand({s1[2], s1[6]}) : '0;
            hsync       <= s1[7];
            vsync       <= s1[3];
            de          <= de_n;
            xpos        <= de_n ? hcnt - H_LO[9:0] : '0;
            ypos        <= de_n ? vcnt - V_LO[9:0] : '0;
            frame_start <= de_n && hcnt == H_LO[9:0] && vcnt == V_LO[9:0];
            locked      <= lt_cur == lt_prev && lt_cur != '0 && lt_cur != SAT;
        end
    end
endmodule
